card_sync_ctrl: RTL and testbench

Owns the shadow copy of all card state words, 14 bits per card. Game logic writes and reads the words through this block. It pushes only the changed words to the per-card draw blocks over their regfile_sync/regfile_sync_done handshake, and only during vertical blanking, so no card changes mid-frame. It sits between the game FSM and the array of card draw instances.

---
 rtl/card_sync_ctrl.sv | 177 +++++++++++++++++
 tb/tb_card_sync_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/card_sync_ctrl.sv
// Shadow register file for card state words; pushes dirty words to the draw blocks during vblank.
// Optional WAIT_DONE timeout with sticky sync_err is enabled by defining CARD_SYNC_TIMEOUT_EN.
module card_sync_ctrl #(
    parameter int N_CARDS = 16,
    parameter int IDX_W   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic               pclk,
    input  logic               rst,
    input  logic               vblnk_in,
    input  logic               wr_en,
    input  logic [IDX_W-1:0]   wr_idx,
    input  logic [13:0]        wr_data,
    input  logic [IDX_W-1:0]   rd_idx,
    output logic [13:0]        rd_data,
    output logic [13:0]        regfile_out,
    output logic [N_CARDS-1:0] regfile_sync,
    input  logic [N_CARDS-1:0] regfile_sync_done,
    output logic               busy,
    output logic               pending,
    output logic               sync_err
);

    if (N_CARDS < 2 || N_CARDS > 64 || (1 << IDX_W) < N_CARDS || TIMEOUT < 1) begin : g_bad_cfg
        $error("card_sync_ctrl: illegal parameter combination");
    end

    typedef enum logic [1:0] {IDLE, SCAN, SYNC, WAIT_DONE} state_t;

    localparam logic [IDX_W:0]   N_LIM    = (IDX_W + 1)'(N_CARDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CARDS - 1);
    localparam logic [N_CARDS-1:0] ONE    = {{(N_CARDS - 1){1'b0}}, 1'b1};

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [13:0]        shadow_q [N_CARDS];
    logic [13:0]        shadow_d [N_CARDS];
    logic [N_CARDS-1:0] dirty_q, dirty_d;
    logic [13:0]        rd_data_q, rd_data_d;
    logic [13:0]        regfile_out_q, regfile_out_d;
    logic [N_CARDS-1:0] regfile_sync_q, regfile_sync_d;
    logic               pending_q, pending_d;
    logic               vblnk_q;
    logic               vb_rise;
    logic               wr_ok;
    logic               rd_ok;
    logic               done_now;
    logic               timeout_hit;

    assign vb_rise  = vblnk_in & ~vblnk_q;
    assign wr_ok    = wr_en && ({1'b0, wr_idx} < N_LIM);
    assign rd_ok    = {1'b0, rd_idx} < N_LIM;
    assign done_now = regfile_sync_done[ptr_q];

`ifdef CARD_SYNC_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sync_err_q, sync_err_d;

    assign timeout_hit = (state_q == WAIT_DONE) && !done_now && (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        cnt_d      = (state_q == WAIT_DONE) ? cnt_q + 1'b1 : '0;
        sync_err_d = sync_err_q | timeout_hit;
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            cnt_q      <= '0;
            sync_err_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            sync_err_q <= sync_err_d;
        end
    end

    assign sync_err = sync_err_q;
`else
    assign timeout_hit = 1'b0;
    assign sync_err    = 1'b0;
`endif

    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        shadow_d       = shadow_q;
        dirty_d        = dirty_q;
        regfile_out_d  = regfile_out_q;
        regfile_sync_d = '0;
        rd_data_d      = rd_ok ? shadow_q[rd_idx] : 14'h0;

        case (state_q)
            IDLE: begin
                if (vb_rise) begin
                    ptr_d   = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                // A closed window leaves remaining dirty bits for the next frame.
                if (!vblnk_in) begin
                    state_d = IDLE;
                end else if (dirty_q[ptr_q]) begin
                    state_d = SYNC;
                end else if (ptr_q == LAST_IDX) begin
                    state_d = IDLE;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            SYNC: begin
                regfile_out_d    = shadow_q[ptr_q];
                regfile_sync_d   = ONE << ptr_q;
                dirty_d[ptr_q]   = 1'b0;
                state_d          = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (done_now || timeout_hit) begin
                    if (timeout_hit) begin
                        dirty_d[ptr_q] = 1'b1;
                    end
                    if (ptr_q == LAST_IDX) begin
                        state_d = IDLE;
                    end else begin
                        ptr_d   = ptr_q + 1'b1;
                        state_d = SCAN;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Applied last so a same-cycle write re-marks a card the SYNC step just cleared.
        if (wr_ok) begin
            shadow_d[wr_idx] = wr_data;
            dirty_d[wr_idx]  = 1'b1;
        end

        pending_d = |dirty_d;
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q        <= IDLE;
            ptr_q          <= '0;
            dirty_q        <= '0;
            rd_data_q      <= '0;
            regfile_out_q  <= '0;
            regfile_sync_q <= '0;
            pending_q      <= 1'b0;
            vblnk_q        <= 1'b0;
            for (int i = 0; i < N_CARDS; i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            dirty_q        <= dirty_d;
            rd_data_q      <= rd_data_d;
            regfile_out_q  <= regfile_out_d;
            regfile_sync_q <= regfile_sync_d;
            pending_q      <= pending_d;
            vblnk_q        <= vblnk_in;
            for (int i = 0; i < N_CARDS; i++) begin
                shadow_q[i] <= shadow_d[i];
            end
        end
    end

    assign rd_data      = rd_data_q;
    assign regfile_out  = regfile_out_q;
    assign regfile_sync = regfile_sync_q;
    assign busy         = (state_q != IDLE);
    assign pending      = pending_q;

endmodule

// File: tb/tb_card_sync_ctrl.sv
// Directed bench for card_sync_ctrl with a draw-block responder returning done one cycle after sync.
// The timeout step is compiled in only when CARD_SYNC_TIMEOUT_EN is defined.
module tb_card_sync_ctrl;

    localparam int N     = 16;
    localparam int IDX_W = 4;

    logic             pclk;
    logic             rst;
    logic             vblnk_in;
    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic [13:0]      wr_data;
    logic [IDX_W-1:0] rd_idx;
    logic [13:0]      rd_data;
    logic [13:0]      regfile_out;
    logic [N-1:0]     regfile_sync;
    logic [N-1:0]     regfile_sync_done;
    logic             busy;
    logic             pending;
    logic             sync_err;

    logic [N-1:0]     done_en;
    logic [29:0]      exp_q[$];
    int               checks = 0;
    int               errors = 0;

    card_sync_ctrl #(.N_CARDS(N), .IDX_W(IDX_W), .TIMEOUT(15)) dut (
        .pclk              (pclk),
        .rst               (rst),
        .vblnk_in          (vblnk_in),
        .wr_en             (wr_en),
        .wr_idx            (wr_idx),
        .wr_data           (wr_data),
        .rd_idx            (rd_idx),
        .rd_data           (rd_data),
        .regfile_out       (regfile_out),
        .regfile_sync      (regfile_sync),
        .regfile_sync_done (regfile_sync_done),
        .busy              (busy),
        .pending           (pending),
        .sync_err          (sync_err)
    );

    // Clock and draw-block responder
    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    always @(posedge pclk) begin
        if (rst) regfile_sync_done <= '0;
        else     regfile_sync_done <= regfile_sync & done_en;
    end

    task automatic tick;
        @(posedge pclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic write_card(input logic [IDX_W-1:0] idx, input logic [13:0] data);
        wr_en   = 1'b1;
        wr_idx  = idx;
        wr_data = data;
        tick();
        wr_en   = 1'b0;
    endtask

    // Opens a vblank window, matches every sync pulse against exp_q, closes the window.
    task automatic run_window(input string tag);
        int n;
        logic [29:0] e;
        n = 0;
        vblnk_in = 1'b1;
        do begin
            tick();
            n++;
            if (regfile_sync != '0) begin
                if (exp_q.size() == 0) begin
                    check({tag, "_extra_sync"}, {2'b0, regfile_sync, regfile_out}, 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    check({tag, "_sync"}, {2'b0, regfile_sync, regfile_out}, {2'b0, e});
                end
            end
        end while (busy && n < 300);
        check({tag, "_idle"}, {31'b0, busy}, 32'h0);
        check({tag, "_all_sent"}, exp_q.size(), 32'h0);
        exp_q.delete();
        vblnk_in = 1'b0;
        tick();
    endtask

    initial begin
        int n;
        logic saw;

        rst      = 1'b1;
        vblnk_in = 1'b0;
        wr_en    = 1'b0;
        wr_idx   = '0;
        wr_data  = '0;
        rd_idx   = '0;
        done_en  = '1;
        tick();
        tick();
        check("rst_rd_data", {18'b0, rd_data}, 32'h0);
        check("rst_regfile_out", {18'b0, regfile_out}, 32'h0);
        check("rst_regfile_sync", {16'b0, regfile_sync}, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'h0);
        check("rst_pending", {31'b0, pending}, 32'h0);
        check("rst_sync_err", {31'b0, sync_err}, 32'h0);
        rst = 1'b0;
        tick();

        // Empty window: 16 SCAN cycles, no sync pulse
        vblnk_in = 1'b1;
        tick();
        n   = 0;
        saw = 1'b0;
        while (busy && n < 40) begin
            if (regfile_sync != '0) saw = 1'b1;
            tick();
            n++;
        end
        check("empty_scan_cycles", n, 32'd16);
        check("empty_no_sync", {31'b0, saw}, 32'h0);
        vblnk_in = 1'b0;
        tick();

        // Two dirty cards, plus read-during-write on idx 9
        write_card(4'd3, 14'h3C03);
        check("pending_after_write", {31'b0, pending}, 32'h1);
        rd_idx = 4'd9;
        write_card(4'd9, 14'h0F01);
        check("rd_same_cycle_old", {18'b0, rd_data}, 32'h0);
        tick();
        check("rd_idx9", {18'b0, rd_data}, 32'h0F01);
        exp_q.push_back({16'h0008, 14'h3C03});
        exp_q.push_back({16'h0200, 14'h0F01});
        run_window("two_cards");
        check("two_cards_pending", {31'b0, pending}, 32'h0);

        // Write idx 5 in the SYNC cycle of idx 5: old value now, new value next window
        write_card(4'd5, 14'h1555);
        vblnk_in = 1'b1;
        repeat (7) tick();
        wr_en   = 1'b1;
        wr_idx  = 4'd5;
        wr_data = 14'h2AA9;
        tick();
        wr_en   = 1'b0;
        check("collide_sync", {16'b0, regfile_sync}, 32'h0020);
        check("collide_old_data", {18'b0, regfile_out}, 32'h1555);
        n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        check("collide_idle", {31'b0, busy}, 32'h0);
        check("collide_pending", {31'b0, pending}, 32'h1);
        vblnk_in = 1'b0;
        tick();
        exp_q.push_back({16'h0020, 14'h2AA9});
        run_window("collide_resend");
        check("collide_pending_clear", {31'b0, pending}, 32'h0);

        // vblank closes while SCAN is at ptr 7 with cards 10 and 12 dirty
        write_card(4'd10, 14'h0AB1);
        write_card(4'd12, 14'h3FFF);
        vblnk_in = 1'b1;
        saw = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (regfile_sync != '0) saw = 1'b1;
        end
        vblnk_in = 1'b0;
        tick();
        if (regfile_sync != '0) saw = 1'b1;
        check("abort_idle", {31'b0, busy}, 32'h0);
        check("abort_no_sync", {31'b0, saw}, 32'h0);
        check("abort_pending", {31'b0, pending}, 32'h1);
        exp_q.push_back({16'h0400, 14'h0AB1});
        exp_q.push_back({16'h1000, 14'h3FFF});
        run_window("abort_resend");
        check("abort_pending_clear", {31'b0, pending}, 32'h0);

        // Reset while stuck in WAIT_DONE for card 0
        done_en[0] = 1'b0;
        write_card(4'd0, 14'h1234);
        vblnk_in = 1'b1;
        repeat (6) tick();
        check("stall_busy", {31'b0, busy}, 32'h1);
        check("stall_out_held", {18'b0, regfile_out}, 32'h1234);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vblnk_in = 1'b0;
        done_en[0] = 1'b1;
        check("midrst_busy", {31'b0, busy}, 32'h0);
        check("midrst_pending", {31'b0, pending}, 32'h0);
        check("midrst_out", {18'b0, regfile_out}, 32'h0);
        rd_idx = 4'd0;
        tick();
        check("midrst_shadow", {18'b0, rd_data}, 32'h0);

`ifdef CARD_SYNC_TIMEOUT_EN
        // Card 2 never answers: timeout re-marks it and the scan moves on to card 3
        done_en[2] = 1'b0;
        write_card(4'd2, 14'h0F03);
        write_card(4'd3, 14'h00F1);
        exp_q.push_back({16'h0004, 14'h0F03});
        exp_q.push_back({16'h0008, 14'h00F1});
        run_window("timeout");
        check("timeout_sync_err", {31'b0, sync_err}, 32'h1);
        check("timeout_pending", {31'b0, pending}, 32'h1);
        done_en[2] = 1'b1;
        exp_q.push_back({16'h0004, 14'h0F03});
        run_window("timeout_resend");
        check("timeout_pending_clear", {31'b0, pending}, 32'h0);
        check("timeout_err_sticky", {31'b0, sync_err}, 32'h1);
`else
        check("sync_err_tied", {31'b0, sync_err}, 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
